// File: rtl/etcpu_inst_mem_ctrl.sv
// Instruction-memory port owner: arbitrates CPU fetch against buffered host loader writes,
// and sequences boot/load so the core stays halted until the program is in memory.
module etcpu_inst_mem_ctrl #(
  parameter int INST_MEM_DEPTH = 512,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIM     = 8,
  localparam int ADD_W         = $clog2(INST_MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_start,
  input  logic             ld_done,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_dat,
  output logic             ld_ready,
  input  logic             cpu_fetch_req,
  input  logic [31:0]      cpu_fetch_addr,
  output logic             cpu_fetch_gnt,
  output logic             cpu_halt,
  output logic             mem_wen,
  output logic [ADD_W-1:0] mem_add,
  output logic [31:0]      mem_dat_in,
  output logic [15:0]      ld_cnt,
  output logic             ld_err
);
  localparam int FA_W = $clog2(FIFO_DEPTH);
  localparam int FC_W = FA_W + 1;
  localparam int SC_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_t;

  state_t           state;
  logic [ADD_W-1:0] fifo_add [FIFO_DEPTH];
  logic [31:0]      fifo_dat [FIFO_DEPTH];
  logic [FA_W-1:0]  wr_ptr, rd_ptr;
  logic [FC_W-1:0]  fifo_cnt;
  logic [SC_W-1:0]  starve_cnt;
  logic             fifo_full, fifo_empty, addr_bad, accept, push, pop, start_clr;
  logic             unused_fetch_bits;

  assign fifo_full  = fifo_cnt == FC_W'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign addr_bad   = (ld_addr[1:0] != 2'b00) || (ld_addr >= 32'(INST_MEM_DEPTH * 4));
  assign accept     = ld_valid & ld_ready;
  assign push       = accept & !addr_bad;
  assign start_clr  = ld_start && (state == IDLE || state == RUN);
  assign unused_fetch_bits = ^{cpu_fetch_addr[31:ADD_W+2], cpu_fetch_addr[1:0]};

  // Fetch wins in RUN unless a buffered write has waited STARVE_LIM cycles.
  always_comb begin
    ld_ready      = (state == LOAD || state == RUN) && !fifo_full;
    cpu_halt      = state != RUN;
    pop           = 1'b0;
    case (state)
      LOAD, DRAIN: pop = !fifo_empty;
      RUN:         pop = !fifo_empty && (!cpu_fetch_req || starve_cnt == SC_W'(STARVE_LIM));
      default:     pop = 1'b0;
    endcase
    mem_wen       = pop;
    cpu_fetch_gnt = (state == RUN) && cpu_fetch_req && !pop;
    mem_add       = '0;
    mem_dat_in    = '0;
    if (pop) begin
      mem_add    = fifo_add[rd_ptr];
      mem_dat_in = fifo_dat[rd_ptr];
    end else if (state == RUN) begin
      mem_add = cpu_fetch_addr[ADD_W+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_add[wr_ptr] <= ld_addr[ADD_W+1:2];
      fifo_dat[wr_ptr] <= ld_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      starve_cnt <= '0;
      ld_cnt     <= '0;
      ld_err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FA_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FA_W'(1);
      fifo_cnt <= fifo_cnt + FC_W'(push) - FC_W'(pop);

      if (state != RUN || pop)
        starve_cnt <= '0;
      else if (!fifo_empty && starve_cnt != SC_W'(STARVE_LIM))
        starve_cnt <= starve_cnt + SC_W'(1);

      if (start_clr)
        ld_cnt <= '0;
      else if (pop && ld_cnt != 16'hFFFF)
        ld_cnt <= ld_cnt + 16'd1;

      if (start_clr)
        ld_err <= 1'b0;
      else if (accept && addr_bad)
        ld_err <= 1'b1;

      case (state)
        IDLE:    if (ld_start) state <= LOAD; else if (ld_done) state <= RUN;
        LOAD:    if (ld_done) state <= DRAIN;
        DRAIN:   if (fifo_empty) state <= RUN;
        RUN:     if (ld_start) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_etcpu_inst_mem_ctrl.sv
// Scoreboard bench for etcpu_inst_mem_ctrl: expected memory writes are queued when the
// loader handshake completes and matched against mem_wen cycles by a negedge monitor.
module tb_etcpu_inst_mem_ctrl;
  localparam int ADD_W = 9;

  logic             clk = 0;
  logic             rst, ld_start, ld_done, ld_valid, cpu_fetch_req;
  logic [31:0]      ld_addr, ld_dat, cpu_fetch_addr;
  logic             ld_ready, cpu_fetch_gnt, cpu_halt, mem_wen, ld_err;
  logic [ADD_W-1:0] mem_add;
  logic [31:0]      mem_dat_in;
  logic [15:0]      ld_cnt;

  typedef struct {logic [ADD_W-1:0] add; logic [31:0] dat;} wr_t;
  wr_t exp_q[$];
  int  errors = 0, checks = 0, writes_seen = 0;

  etcpu_inst_mem_ctrl dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_done(ld_done), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_dat(ld_dat), .ld_ready(ld_ready), .cpu_fetch_req(cpu_fetch_req),
    .cpu_fetch_addr(cpu_fetch_addr), .cpu_fetch_gnt(cpu_fetch_gnt), .cpu_halt(cpu_halt),
    .mem_wen(mem_wen), .mem_add(mem_add), .mem_dat_in(mem_dat_in), .ld_cnt(ld_cnt),
    .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every memory write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_wen) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: add=%h dat=%h, required no write", mem_add, mem_dat_in);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_add !== e.add || mem_dat_in !== e.dat) begin
          errors++;
          $display("FAIL write_data: add=%h dat=%h, required add=%h dat=%h",
                   mem_add, mem_dat_in, e.add, e.dat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one write; queue it as expected only if the handshake completes with a legal address.
  task automatic offer(input logic [31:0] a, input logic [31:0] d, output bit taken);
    wr_t e;
    ld_valid = 1; ld_addr = a; ld_dat = d;
    taken = ld_ready;
    if (taken && a[1:0] == 2'b00 && a < 32'd2048) begin
      e.add = a[ADD_W+1:2]; e.dat = d;
      exp_q.push_back(e);
    end
    step();
    ld_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; ld_start = 0; ld_done = 0; ld_valid = 0; ld_addr = 0; ld_dat = 0;
    cpu_fetch_req = 0; cpu_fetch_addr = 0;
    step(); step();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({cpu_halt, ld_ready, cpu_fetch_gnt, mem_wen} !== 4'b1000 || mem_add !== '0 ||
        mem_dat_in !== 0 || ld_cnt !== 0 || ld_err !== 0) begin
      errors++;
      $display("FAIL reset_outputs: halt=%b rdy=%b gnt=%b wen=%b add=%h dat=%h cnt=%0d err=%b, required 1 0 0 0 0 0 0 0",
               cpu_halt, ld_ready, cpu_fetch_gnt, mem_wen, mem_add, mem_dat_in, ld_cnt, ld_err);
    end
  endtask

  task automatic test_load();
    bit t;
    ld_start = 1; step(); ld_start = 0;
    for (int i = 0; i < 4; i++) begin
      offer(32'(4 * i), 32'hA0 + 32'(i), t);
      checks++;
      if (!t) begin errors++; $display("FAIL load_ready: ld_ready=0 at write %0d, required 1", i); end
    end
    ld_done = 1;
    @(negedge clk);
    checks++;
    if (cpu_halt !== 1) begin errors++; $display("FAIL load_halt: halt=%b, required 1", cpu_halt); end
    step(); ld_done = 0;
    @(negedge clk);
    checks++;
    if (cpu_halt !== 1 || ld_ready !== 0) begin
      errors++; $display("FAIL drain_state: halt=%b rdy=%b, required 1 0", cpu_halt, ld_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (cpu_halt !== 0 || ld_ready !== 1) begin
      errors++; $display("FAIL run_release: halt=%b rdy=%b, required 0 1", cpu_halt, ld_ready);
    end
    checks++;
    if (ld_cnt !== 16'd4 || writes_seen != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL load_count: ld_cnt=%0d writes=%0d pending=%0d, required 4 4 0",
                         ld_cnt, writes_seen, exp_q.size());
    end
  endtask

  task automatic test_bad_addr();
    bit t0, t1, t2;
    int w0;
    step();
    ld_start = 1; step(); ld_start = 0;
    checks++;
    if (ld_cnt !== 0 || ld_err !== 0 || cpu_halt !== 1) begin
      errors++; $display("FAIL load_clear: cnt=%0d err=%b halt=%b, required 0 0 1", ld_cnt, ld_err, cpu_halt);
    end
    w0 = writes_seen;
    offer(32'h802, 32'hDEAD, t0);
    offer(32'd2048, 32'hBEEF, t1);
    step(); step();
    checks++;
    if (!t0 || !t1 || ld_err !== 1 || ld_cnt !== 0 || writes_seen != w0) begin
      errors++; $display("FAIL bad_addr: taken=%b%b err=%b cnt=%0d writes=%0d, required 11 1 0 %0d",
                         t0, t1, ld_err, ld_cnt, writes_seen, w0);
    end
    offer(32'h7FC, 32'h5555_AAAA, t2);
    ld_done = 1; step(); ld_done = 0;
    step(); step();
    checks++;
    if (!t2 || ld_cnt !== 1 || ld_err !== 1 || cpu_halt !== 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL last_word: taken=%b cnt=%0d err=%b halt=%b pending=%0d, required 1 1 1 0 0",
                         t2, ld_cnt, ld_err, cpu_halt, exp_q.size());
    end
  endtask

  task automatic test_starve();
    bit t;
    int k;
    cpu_fetch_req = 1; cpu_fetch_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (cpu_fetch_gnt !== 1 || mem_add !== 9'h040) begin
      errors++; $display("FAIL fetch_gnt: gnt=%b add=%h, required 1 040", cpu_fetch_gnt, mem_add);
    end
    step();
    offer(32'h20, 32'h1234, t);
    k = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_wen) begin
        k = c;
        checks++;
        if (cpu_fetch_gnt !== 0) begin errors++; $display("FAIL steal_gnt: gnt=%b, required 0", cpu_fetch_gnt); end
        break;
      end
      checks++;
      if (cpu_fetch_gnt !== 1) begin
        errors++; $display("FAIL starve_gnt: gnt=%b at cycle %0d, required 1", cpu_fetch_gnt, c);
      end
    end
    checks++;
    if (!t || k != 8) begin errors++; $display("FAIL starve_delay: taken=%b delay=%0d, required 1 8", t, k); end
    @(negedge clk);
    checks++;
    if (cpu_fetch_gnt !== 1 || mem_wen !== 0) begin
      errors++; $display("FAIL after_steal: gnt=%b wen=%b, required 1 0", cpu_fetch_gnt, mem_wen);
    end
  endtask

  task automatic test_backpressure();
    bit t;
    int n = 0, first_stall = -1, bound = 0;
    step();
    while (n < 8 && bound < 200) begin
      offer(32'h40 + 32'(4 * n), $urandom, t);
      if (t) n++;
      else if (first_stall < 0) first_stall = n;
      bound++;
    end
    checks++;
    if (n != 8 || first_stall != 4) begin
      errors++; $display("FAIL backpressure: accepted=%0d first_stall_after=%0d, required 8 4", n, first_stall);
    end
    cpu_fetch_req = 0;
    bound = 0;
    while (exp_q.size() != 0 && bound < 50) begin step(); bound++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain_run: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_boot();
    rst = 1; step(); rst = 0;
    ld_done = 1; step(); ld_done = 0;
    cpu_fetch_req = 1; cpu_fetch_addr = 32'h0000_0804;
    @(negedge clk);
    checks++;
    if (cpu_halt !== 0 || cpu_fetch_gnt !== 1 || mem_add !== 9'h001) begin
      errors++; $display("FAIL boot_wrap: halt=%b gnt=%b add=%h, required 0 1 001", cpu_halt, cpu_fetch_gnt, mem_add);
    end
    step();
  endtask

  task automatic test_reset_drain();
    bit t;
    int w0;
    cpu_fetch_addr = 32'h10;
    for (int i = 0; i < 4; i++) offer(32'h100 + 32'(4 * i), 32'hC0 + 32'(i), t);
    ld_start = 1; step(); ld_start = 0;
    ld_done = 1; step(); ld_done = 0;
    @(negedge clk);
    checks++;
    if (cpu_halt !== 1 || ld_ready !== 0 || mem_wen !== 1 || exp_q.size() != 3) begin
      errors++; $display("FAIL drain_setup: halt=%b rdy=%b wen=%b pending=%0d, required 1 0 1 3",
                         cpu_halt, ld_ready, mem_wen, exp_q.size());
    end
    rst = 1;
    step();
    exp_q.delete();
    w0 = writes_seen;
    @(negedge clk);
    checks++;
    if ({cpu_halt, ld_ready, cpu_fetch_gnt, mem_wen} !== 4'b1000 || mem_add !== '0 ||
        mem_dat_in !== 0 || ld_cnt !== 0 || ld_err !== 0) begin
      errors++;
      $display("FAIL drain_reset: halt=%b rdy=%b gnt=%b wen=%b add=%h dat=%h cnt=%0d err=%b, required 1 0 0 0 0 0 0 0",
               cpu_halt, ld_ready, cpu_fetch_gnt, mem_wen, mem_add, mem_dat_in, ld_cnt, ld_err);
    end
    rst = 0;
    repeat (6) step();
    checks++;
    if (writes_seen != w0) begin
      errors++; $display("FAIL post_reset_writes: writes=%0d, required %0d", writes_seen - w0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_bad_addr();
    test_starve();
    test_backpressure();
    test_boot();
    test_reset_drain();
    cpu_fetch_req = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
